// File: rtl/rx_ltssm_sequencer.sv
// RX LTSSM substate sequencer: drives the master's substate, owns the shared ms timeout timer,
// latches the active lane count and reports link-up. Define RX_LTSSM_FAST_TIMER_EN for a 16-cycle ms tick.
module rx_ltssm_sequencer #(
  parameter int MAXLANES        = 16,
  parameter int TICKS_PER_MS    = 250000,
  parameter int DETECT_QUIET_MS = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       forceDetect,
  input  logic       rxElectricalIdle,
  input  logic [4:0] numberOfDetectedLanes,
  input  logic       finish,
  input  logic [3:0] exitTo,
  input  logic [5:0] setTimer,
  input  logic       enableTimer,
  input  logic       resetTimer,
  output logic [3:0] substate,
  output logic       timeOut,
  output logic       timerOwner,
  output logic [4:0] activeLanes,
  output logic       linkUp
);

  typedef enum logic [3:0] {
    DETECT_QUIET      = 4'd0,
    DETECT_ACTIVE     = 4'd1,
    POLLING_ACTIVE    = 4'd2,
    POLLING_CONFIG    = 4'd3,
    CFG_WIDTH_START   = 4'd4,
    CFG_WIDTH_ACCEPT  = 4'd5,
    CFG_LANENUM_WAIT  = 4'd6,
    CFG_LANENUM_ACCEPT= 4'd7,
    CFG_COMPLETE      = 4'd8,
    CFG_IDLE          = 4'd9,
    L0                = 4'd10
  } substate_e;

  localparam int PW = ($clog2(TICKS_PER_MS) < 5) ? 5 : $clog2(TICKS_PER_MS);
`ifdef RX_LTSSM_FAST_TIMER_EN
  localparam logic [PW-1:0] WRAP = PW'(15);
`else
  localparam logic [PW-1:0] WRAP = PW'(TICKS_PER_MS - 1);
`endif
  localparam logic [4:0] MAX_LANES_C = 5'(MAXLANES);
  localparam logic [5:0] QUIET_MS_C  = 6'(DETECT_QUIET_MS);

  substate_e       state_r;
  substate_e       next_s;
  logic [4:0]      lanes_r;
  logic [4:0]      lanes_next_s;
  logic [PW-1:0]   prescale_r;
  logic [PW-1:0]   prescale_next_s;
  logic [5:0]      ms_r;
  logic [5:0]      ms_next_s;
  logic            timeout_r;
  logic            timeout_next_s;
  logic            seq_own_s;
  logic            master_own_s;
  logic            timer_en_s;
  logic            timer_clr_s;
  logic [5:0]      target_s;
  logic            next_master_s;

  // Substate transition and lane latch decision.
  always_comb begin
    next_s       = state_r;
    lanes_next_s = lanes_r;
    if (forceDetect) begin
      next_s = DETECT_QUIET;
    end else begin
      case (state_r)
        DETECT_QUIET: begin
          if (!rxElectricalIdle || timeout_r) next_s = DETECT_ACTIVE;
          else                                next_s = state_r;
        end
        DETECT_ACTIVE: begin
          if (numberOfDetectedLanes != 5'd0) begin
            next_s = POLLING_ACTIVE;
            if (numberOfDetectedLanes > MAX_LANES_C) lanes_next_s = MAX_LANES_C;
            else                                     lanes_next_s = numberOfDetectedLanes;
          end else begin
            next_s = DETECT_QUIET;
          end
        end
        POLLING_ACTIVE, POLLING_CONFIG, CFG_WIDTH_START, CFG_WIDTH_ACCEPT,
        CFG_LANENUM_WAIT, CFG_LANENUM_ACCEPT, CFG_COMPLETE, CFG_IDLE: begin
          // Only a step to the immediate successor is legal; anything else restarts training.
          if (finish) begin
            if (exitTo == (state_r + 4'd1)) next_s = substate_e'(exitTo);
            else                            next_s = DETECT_QUIET;
          end else begin
            next_s = state_r;
          end
        end
        L0: begin
          if (rxElectricalIdle) next_s = DETECT_QUIET;
          else                  next_s = state_r;
        end
        default: next_s = DETECT_QUIET;
      endcase
    end
  end

  // Timer ownership, clear and count.
  always_comb begin
    seq_own_s       = (state_r == DETECT_QUIET);
    master_own_s    = (state_r >= POLLING_ACTIVE) && (state_r <= CFG_IDLE);
    next_master_s   = (next_s >= POLLING_ACTIVE) && (next_s <= CFG_IDLE);
    timer_en_s      = seq_own_s || (master_own_s && enableTimer);
    target_s        = seq_own_s ? QUIET_MS_C : setTimer;
    timer_clr_s     = forceDetect || (next_s != state_r) || (master_own_s && resetTimer) ||
                      !(seq_own_s || master_own_s);
    prescale_next_s = prescale_r;
    ms_next_s       = ms_r;
    timeout_next_s  = timeout_r;
    if (timer_clr_s) begin
      prescale_next_s = {PW{1'b0}};
      ms_next_s       = 6'd0;
      timeout_next_s  = 1'b0;
    end else if (timer_en_s) begin
      if (prescale_r == WRAP) begin
        prescale_next_s = {PW{1'b0}};
        if (ms_r != 6'd63) ms_next_s = ms_r + 6'd1;
        else               ms_next_s = ms_r;
      end else begin
        prescale_next_s = prescale_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (ms_r >= target_s) timeout_next_s = 1'b1;
      else                  timeout_next_s = timeout_r;
    end else begin
      prescale_next_s = prescale_r;
    end
  end

  // State, timer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= DETECT_QUIET;
      lanes_r     <= 5'd0;
      prescale_r  <= {PW{1'b0}};
      ms_r        <= 6'd0;
      timeout_r   <= 1'b0;
      timerOwner  <= 1'b0;
      linkUp      <= 1'b0;
    end else begin
      state_r     <= next_s;
      lanes_r     <= lanes_next_s;
      prescale_r  <= prescale_next_s;
      ms_r        <= ms_next_s;
      timeout_r   <= timeout_next_s;
      timerOwner  <= next_master_s;
      linkUp      <= (next_s == L0);
    end
  end

  assign substate    = state_r;
  assign timeOut     = timeout_r;
  assign activeLanes = lanes_r;

endmodule

// File: tb/tb_rx_ltssm_sequencer.sv
// Self-checking bench for rx_ltssm_sequencer: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model that counts enabled cycles since the last clear.
module tb_rx_ltssm_sequencer;
  localparam int TICKS = 16;
  localparam int QUIET = 12;
  localparam int MAXL  = 16;

  logic       clk = 1'b0;
  logic       reset, forceDetect, rxElectricalIdle, finish, enableTimer, resetTimer;
  logic [4:0] numberOfDetectedLanes;
  logic [3:0] exitTo;
  logic [5:0] setTimer;
  logic [3:0] substate;
  logic       timeOut, timerOwner, linkUp;
  logic [4:0] activeLanes;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rx_ltssm_sequencer #(.MAXLANES(MAXL), .TICKS_PER_MS(TICKS), .DETECT_QUIET_MS(QUIET)) dut (
    .clk(clk), .reset(reset), .forceDetect(forceDetect), .rxElectricalIdle(rxElectricalIdle),
    .numberOfDetectedLanes(numberOfDetectedLanes), .finish(finish), .exitTo(exitTo),
    .setTimer(setTimer), .enableTimer(enableTimer), .resetTimer(resetTimer),
    .substate(substate), .timeOut(timeOut), .timerOwner(timerOwner),
    .activeLanes(activeLanes), .linkUp(linkUp)
  );

  // Reference model: substate number, enabled-cycle count since last timer clear, sticky timeout.
  int  m_sub = 0, m_cnt = 0, m_lanes = 0;
  bit  m_to = 1'b0;
  int  n_sub, n_lanes, n_tgt;
  bit  n_clr, n_en, m_master;

  always @* begin
    m_master = (m_sub >= 2) && (m_sub <= 9);
    n_sub    = m_sub;
    n_lanes  = m_lanes;
    if (forceDetect) n_sub = 0;
    else if (m_sub == 0) begin
      if (!rxElectricalIdle || m_to) n_sub = 1;
    end else if (m_sub == 1) begin
      if (numberOfDetectedLanes != 0) begin
        n_sub   = 2;
        n_lanes = (int'(numberOfDetectedLanes) > MAXL) ? MAXL : int'(numberOfDetectedLanes);
      end else n_sub = 0;
    end else if (m_master) begin
      if (finish) n_sub = (int'(exitTo) == m_sub + 1) ? m_sub + 1 : 0;
    end else if (m_sub == 10) begin
      if (rxElectricalIdle) n_sub = 0;
    end else n_sub = 0;
    n_clr = forceDetect || (n_sub != m_sub) || (m_master && resetTimer) || m_sub == 1 || m_sub == 10;
    n_en  = (m_sub == 0) || (m_master && enableTimer);
    n_tgt = (m_sub == 0) ? QUIET : int'(setTimer);
  end

  always @(posedge clk) begin
    if (reset) begin
      m_sub <= 0; m_cnt <= 0; m_to <= 1'b0; m_lanes <= 0;
    end else begin
      m_sub   <= n_sub;
      m_lanes <= n_lanes;
      if (n_clr) begin
        m_cnt <= 0; m_to <= 1'b0;
      end else if (n_en) begin
        if ((((m_cnt / TICKS) > 63) ? 63 : (m_cnt / TICKS)) >= n_tgt) m_to <= 1'b1;
        if (m_cnt < 100000) m_cnt <= m_cnt + 1;
      end
    end
  end

  logic [11:0] exp_vec;
  logic [11:0] dut_vec;
  always_comb exp_vec = {4'(m_sub), m_to, (m_sub >= 2 && m_sub <= 9), 5'(m_lanes), (m_sub == 10)};
  always_comb dut_vec = {substate, timeOut, timerOwner, activeLanes, linkUp};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic goto_polling(input logic [4:0] lanes);
    forceDetect = 1'b1; finish = 1'b0; step();
    forceDetect = 1'b0; rxElectricalIdle = 1'b0; numberOfDetectedLanes = lanes; step();
    step();
  endtask

  task automatic walk_to(input int target);
    for (int s = 2; s < target; s++) begin
      finish = 1'b1; exitTo = 4'(s + 1); step();
      finish = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      forceDetect = 1'($urandom_range(0, 1)); rxElectricalIdle = 1'($urandom_range(0, 1));
      finish = 1'($urandom_range(0, 1)); exitTo = 4'($urandom_range(0, 15));
      setTimer = 6'($urandom_range(0, 63)); enableTimer = 1'($urandom_range(0, 1));
      resetTimer = 1'($urandom_range(0, 1)); numberOfDetectedLanes = 5'($urandom_range(0, 31));
      step();
      checks++;
      if (dut_vec !== 12'd0) begin
        errors++; $display("FAIL reset_values: got %h expected %h", dut_vec, 12'd0);
      end
    end
  endtask

  task automatic test_detect_timeout();
    int first_n;
    int to_cycles;
    first_n = -1; to_cycles = 0;
    reset = 1'b1; rxElectricalIdle = 1'b1; forceDetect = 1'b0; finish = 1'b0;
    enableTimer = 1'b0; resetTimer = 1'b0; numberOfDetectedLanes = 5'd20; setTimer = 6'd5;
    step();
    reset = 1'b0;
    for (int n = 1; n <= 196; n++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL detect_model n=%0d: got %h expected %h", n, dut_vec, exp_vec);
      end
      if (substate == 4'd1 && first_n < 0) first_n = n;
      if (timeOut) to_cycles++;
    end
    checks++;
    if (first_n != 194) begin
      errors++; $display("FAIL detect_latency: got %0d expected 194", first_n);
    end
    checks++;
    if (to_cycles != 1) begin
      errors++; $display("FAIL detect_timeout_width: got %0d expected 1", to_cycles);
    end
    checks++;
    if ({substate, activeLanes} !== {4'd2, 5'd16}) begin
      errors++; $display("FAIL lane_clamp: got sub=%0d lanes=%0d expected sub=2 lanes=16", substate, activeLanes);
    end
  endtask

  task automatic test_zero_lanes();
    forceDetect = 1'b1; step();
    forceDetect = 1'b0; rxElectricalIdle = 1'b0; numberOfDetectedLanes = 5'd0;
    step();
    checks++;
    if (substate !== 4'd1) begin
      errors++; $display("FAIL zero_lanes_enter: got %0d expected 1", substate);
    end
    rxElectricalIdle = 1'b1;
    step();
    checks++;
    if (dut_vec !== exp_vec || substate !== 4'd0) begin
      errors++; $display("FAIL zero_lanes_exit: got %h expected %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_walk();
    goto_polling(5'd7);
    for (int s = 2; s <= 9; s++) begin
      finish = 1'b1; exitTo = 4'(s + 1); step();
      finish = 1'b0; exitTo = 4'($urandom_range(0, 15));
      checks++;
      if (substate !== 4'(s + 1)) begin
        errors++; $display("FAIL walk_step s=%0d: got %0d expected %0d", s, substate, s + 1);
      end
      step();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL walk_hold s=%0d: got %h expected %h", s, dut_vec, exp_vec);
      end
    end
    checks++;
    if ({linkUp, activeLanes} !== {1'b1, 5'd7}) begin
      errors++; $display("FAIL linkup: got link=%0b lanes=%0d expected link=1 lanes=7", linkUp, activeLanes);
    end
    rxElectricalIdle = 1'b1; step();
    checks++;
    if ({substate, linkUp, activeLanes} !== {4'd0, 1'b0, 5'd7}) begin
      errors++; $display("FAIL l0_exit: got sub=%0d link=%0b lanes=%0d expected 0 0 7", substate, linkUp, activeLanes);
    end
  endtask

  task automatic test_protocol_error();
    goto_polling(5'd4); walk_to(5);
    finish = 1'b1; exitTo = 4'd7; step(); finish = 1'b0;
    checks++;
    if (substate !== 4'd0) begin
      errors++; $display("FAIL bad_exit: got %0d expected 0", substate);
    end
    goto_polling(5'd4); walk_to(8);
    forceDetect = 1'b1; finish = 1'b1; exitTo = 4'd9; step();
    forceDetect = 1'b0; finish = 1'b0;
    checks++;
    if (substate !== 4'd0 || dut_vec !== exp_vec) begin
      errors++; $display("FAIL force_vs_finish: got %h expected %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_master_timer();
    int n_to;
    setTimer = 6'd2; enableTimer = 1'b1; resetTimer = 1'b0;
    goto_polling(5'd3);
    n_to = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL master_model n=%0d: got %h expected %h", n, dut_vec, exp_vec);
      end
      if (timeOut && n_to < 0) n_to = n;
    end
    checks++;
    if (n_to != 33) begin
      errors++; $display("FAIL master_timeout: got %0d expected 33", n_to);
    end
    goto_polling(5'd3);
    n_to = -1;
    for (int n = 1; n <= 60; n++) begin
      resetTimer = (n == 20);
      step();
      if (timeOut && n_to < 0) n_to = n;
    end
    resetTimer = 1'b0;
    checks++;
    if (n_to != 53) begin
      errors++; $display("FAIL master_reset_timer: got %0d expected 53", n_to);
    end
  endtask

  task automatic test_reset_mid();
    enableTimer = 1'b0;
    goto_polling(5'd12); walk_to(7);
    setTimer = 6'd0; enableTimer = 1'b1; step();
    checks++;
    if ({substate, timeOut} !== {4'd7, 1'b1}) begin
      errors++; $display("FAIL zero_target: got sub=%0d to=%0b expected 7 1", substate, timeOut);
    end
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if (dut_vec !== 12'd0) begin
      errors++; $display("FAIL reset_mid: got %h expected %h", dut_vec, 12'd0);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 499) == 0);
      forceDetect = ($urandom_range(0, 99) == 0);
      rxElectricalIdle = (m_sub == 10) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
      numberOfDetectedLanes = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      finish = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 7)       exitTo = 4'(m_sub + 1);
      else if (r == 7) exitTo = 4'd0;
      else             exitTo = 4'($urandom_range(0, 15));
      setTimer    = 6'($urandom_range(0, 3));
      enableTimer = ($urandom_range(0, 3) != 0);
      resetTimer  = ($urandom_range(0, 29) == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL random i=%0d: got %h expected %h", i, dut_vec, exp_vec);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; forceDetect = 1'b0; rxElectricalIdle = 1'b1; finish = 1'b0; exitTo = 4'd0;
    setTimer = 6'd0; enableTimer = 1'b0; resetTimer = 1'b0; numberOfDetectedLanes = 5'd0;
    @(negedge clk);
    test_reset();
    test_detect_timeout();
    test_zero_lanes();
    test_walk();
    test_protocol_error();
    test_master_timer();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
